id_rf_stall_ctrl: RTL and testbench
===================================

// Module: id_rf_stall_ctrl
// PURPOSE
//  ID->RF pipeline register and stall responder. Consumes the load-use hazard
//  request (hz_mux_enable low = hazard). On a hazard it freezes the PC and the
//  IF/ID register, and injects LOAD_LAT NOP bubbles into ID/RF. Branch flush
//  kills the ID/RF slot. Sits between the IF/ID register and the RF stage.
// PARAMETERS
//  OPCODE_W    4        opcode width
//  REG_W       3        register specifier width
//  LOAD_LAT    1        bubbles inserted per load-use hazard; legal range 1..7
//  NOP_OPCODE  4'b1111  opcode written into ID/RF for a bubble or a flush
//  CNT_W       16       perf counter width (used only with STALL_PERF_CNT_EN)
// PORTS
//  clock          in   1         rising-edge clock
//  reset          in   1         asynchronous, active-high reset
//  hz_mux_enable  in   1         0 = load-use hazard detected this cycle
//  flush          in   1         branch redirect; kill ID/RF contents
//  if_id_valid    in   1         IF/ID slot holds a live instruction
//  if_id_opcode   in   OPCODE_W  IF/ID opcode
//  if_id_src1     in   REG_W     IF/ID source 1
//  if_id_src2     in   REG_W     IF/ID source 2
//  if_id_dest     in   REG_W     IF/ID destination
//  id_rf_valid    out  1         ID/RF slot live (registered)
//  id_rf_opcode   out  OPCODE_W  ID/RF opcode (registered)
//  id_rf_src1     out  REG_W     ID/RF source 1 (registered)
//  id_rf_src2     out  REG_W     ID/RF source 2 (registered)
//  id_rf_dest     out  REG_W     ID/RF destination (registered)
//  pc_enable      out  1         0 = hold the PC (combinational)
//  if_id_enable   out  1         0 = hold the IF/ID register (combinational)
//  stall_active   out  1         1 = a bubble is being inserted this cycle
//  stall_count    out  CNT_W     saturating bubble count (only with the macro)
// BEHAVIOUR
//  Reset: async and immediate. Clears id_rf_valid and all reg fields to 0.
//   Sets id_rf_opcode to NOP_OPCODE, state to RUN, bubble counter to 0.
//   While reset is high: pc_enable=1, if_id_enable=1, stall_active=0.
//  FSM states: RUN and STALL.
//  stall_req = (state==RUN) & ~hz_mux_enable & if_id_valid & ~flush.
//  stall_active = stall_req | ((state==STALL) & ~flush).
//  pc_enable = if_id_enable = ~stall_active. Same-cycle response, no latency.
//  RUN, no stall_req: at the clock edge, ID/RF takes all if_id_* fields.
//   id_rf_valid takes if_id_valid. Latency is 1 cycle.
//  RUN, stall_req: at the edge, ID/RF loads a bubble (valid 0, NOP, fields 0).
//   LOAD_LAT==1: stay in RUN. The bubble drops Valid_out_ID_RF, so the hazard
//   unit releases on the next cycle.
//   LOAD_LAT>1: go to STALL with cnt=LOAD_LAT-1.
//  STALL: hz_mux_enable is ignored. Each edge inserts one bubble and does
//   cnt-=1. When cnt reaches 0, go to RUN.
//   Total bubbles per hazard = LOAD_LAT. The held instruction is never lost.
//  flush: highest priority in any state. At the edge: id_rf_valid=0, opcode
//   NOP, state RUN, cnt 0. No stall in that cycle (enables = 1).
//  if_id_valid=0 with hz_mux_enable=0: no stall; the invalid slot passes.
//  Reset asserted mid-STALL: abandons the stall. No residual bubbles after
//   reset is released.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: adds the stall_count port. The counter increments
//   once per edge with stall_active=1 and saturates at all-ones. It clears on
//   reset only; flush does not clear it.
//  STALL_PERF_CNT_EN undefined: no stall_count port and no counter logic.
//   All other behaviour is identical.
// STRUCTURE
//  Package pipe_pkg holds OPCODE_W, REG_W, NOP_OPCODE, OP_LW=4'b0100, and the
//   state encoding (RUN=1'b0, STALL=1'b1).
//  One sub-module, stall_perf_counter (saturating, CNT_W), is instantiated
//   only under STALL_PERF_CNT_EN.
// TESTING
//  1 LOAD_LAT=1. ID/RF holds LW dest r3; IF/ID holds ADD src1=r3 (valid);
//    hz_mux_enable=0 -> that cycle pc_enable=if_id_enable=0. Next edge:
//    id_rf_valid=0, opcode=4'b1111. Following edge: ID/RF=ADD, valid=1.
//  2 LOAD_LAT=3, same hazard -> enables low for 3 cycles; 3 NOP bubbles;
//    ADD enters ID/RF on the 4th edge. hz_mux_enable toggling in STALL has
//    no effect.
//  3 LOAD_LAT=3, flush=1 in the 2nd stall cycle -> enables=1 that cycle.
//    Next edge: id_rf_valid=0, state RUN; the next IF/ID instruction loads.
//  4 Reset pulsed between clock edges in STALL -> id_rf_valid=0, opcode=NOP,
//    enables=1 immediately. After release, ADD passes with no bubbles.
//  5 hz_mux_enable=0 with if_id_valid=0 -> no stall; enables stay 1;
//    id_rf_valid=0 at the next edge.
//  6 STALL_PERF_CNT_EN, LOAD_LAT=2, two hazards -> stall_count=4.
//    With CNT_W=2 and 3 hazards -> stall_count saturates at 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the ID/RF stall FSM state encoding.
// Used by id_rf_stall_ctrl and by its bench.
package pipe_pkg;

  localparam int OPCODE_W = 4;
  localparam int REG_W    = 3;
  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 4'b1111;
  localparam logic [OPCODE_W-1:0] OP_LW      = 4'b0100;

  // Remaining-bubble counter width; wide enough for LOAD_LAT up to 7.
  localparam int BCNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Bubbles still owed after the one inserted on the hazard edge itself.
  function automatic logic [BCNT_W-1:0] stall_cnt_init(input int load_lat);
    return BCNT_W'(load_lat - 1);
  endfunction

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating count of edges on which a bubble was inserted.
// Exists only when STALL_PERF_CNT_EN is defined; otherwise this file is empty.
`ifdef STALL_PERF_CNT_EN
module stall_perf_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Cleared only by reset; sticks at all-ones once it gets there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/id_rf_stall_ctrl.sv
// ID->RF pipeline register with load-use stall response and branch flush.
// Optional macro STALL_PERF_CNT_EN adds a saturating stall_count output.
module id_rf_stall_ctrl
  import pipe_pkg::state_t;
  import pipe_pkg::RUN;
  import pipe_pkg::STALL;
  import pipe_pkg::BCNT_W;
  import pipe_pkg::stall_cnt_init;
#(
  parameter int OPCODE_W = pipe_pkg::OPCODE_W,
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int LOAD_LAT = 1,
  parameter logic [OPCODE_W-1:0] NOP_OPCODE = pipe_pkg::NOP_OPCODE
`ifdef STALL_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                hz_mux_enable,
  input  logic                flush,
  input  logic                if_id_valid,
  input  logic [OPCODE_W-1:0] if_id_opcode,
  input  logic [REG_W-1:0]    if_id_src1,
  input  logic [REG_W-1:0]    if_id_src2,
  input  logic [REG_W-1:0]    if_id_dest,
  output logic                id_rf_valid,
  output logic [OPCODE_W-1:0] id_rf_opcode,
  output logic [REG_W-1:0]    id_rf_src1,
  output logic [REG_W-1:0]    id_rf_src2,
  output logic [REG_W-1:0]    id_rf_dest,
  output logic                pc_enable,
  output logic                if_id_enable,
  output logic                stall_active
`ifdef STALL_PERF_CNT_EN
  , output logic [CNT_W-1:0]  stall_count
`endif
);

  state_t              r_state;
  logic [BCNT_W-1:0]   r_cnt;
  logic                r_valid;
  logic [OPCODE_W-1:0] r_opcode;
  logic [REG_W-1:0]    r_src1;
  logic [REG_W-1:0]    r_src2;
  logic [REG_W-1:0]    r_dest;

  logic w_stall_req;
  logic w_stall_active;

  // A hazard is honoured only from RUN, only for a live IF/ID slot, and
  // never in a flush cycle; STALL keeps bubbling regardless of hz_mux_enable.
  assign w_stall_req    = (r_state == RUN) & ~hz_mux_enable & if_id_valid & ~flush;
  assign w_stall_active = ~reset & (w_stall_req | ((r_state == STALL) & ~flush));

  // Enables are same-cycle: low means upstream must hold PC and IF/ID.
  assign stall_active = w_stall_active;
  assign pc_enable    = ~w_stall_active;
  assign if_id_enable = ~w_stall_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_opcode <= NOP_OPCODE;
      r_src1   <= '0;
      r_src2   <= '0;
      r_dest   <= '0;
    end else if (flush) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_opcode <= NOP_OPCODE;
      r_src1   <= '0;
      r_src2   <= '0;
      r_dest   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_stall_req) begin
            r_valid  <= 1'b0;
            r_opcode <= NOP_OPCODE;
            r_src1   <= '0;
            r_src2   <= '0;
            r_dest   <= '0;
            if (LOAD_LAT > 1) begin
              r_state <= STALL;
              r_cnt   <= stall_cnt_init(LOAD_LAT);
            end
          end else begin
            r_valid  <= if_id_valid;
            r_opcode <= if_id_opcode;
            r_src1   <= if_id_src1;
            r_src2   <= if_id_src2;
            r_dest   <= if_id_dest;
          end
        end
        STALL: begin
          r_valid  <= 1'b0;
          r_opcode <= NOP_OPCODE;
          r_src1   <= '0;
          r_src2   <= '0;
          r_dest   <= '0;
          r_cnt    <= r_cnt - 1'b1;
          if (r_cnt == BCNT_W'(1)) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign id_rf_valid  = r_valid;
  assign id_rf_opcode = r_opcode;
  assign id_rf_src1   = r_src1;
  assign id_rf_src2   = r_src2;
  assign id_rf_dest   = r_dest;

`ifdef STALL_PERF_CNT_EN
  stall_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_stall_active),
    .o_count (stall_count)
  );
`endif

endmodule

// File: tb/tb_id_rf_stall_ctrl.sv
// Directed bench for id_rf_stall_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share
// stimulus; STALL_PERF_CNT_EN adds two counter instances (CNT_W=16 and CNT_W=2).
module tb_id_rf_stall_ctrl;
  import pipe_pkg::*;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  logic       clock;
  logic       reset;
  logic       hz_mux_enable;
  logic       flush;
  logic       if_id_valid;
  logic [3:0] if_id_opcode;
  logic [2:0] if_id_src1;
  logic [2:0] if_id_src2;
  logic [2:0] if_id_dest;

  logic       a_valid, a_pc_en, a_ifid_en, a_stall;
  logic [3:0] a_opcode;
  logic [2:0] a_src1, a_src2, a_dest;
  logic       b_valid, b_pc_en, b_ifid_en, b_stall;
  logic [3:0] b_opcode;
  logic [2:0] b_src1, b_src2, b_dest;

  int n_vec;
  int n_miss;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] a_count, b_count, p_count;
  logic [1:0]  s_count;
  logic        p_valid, p_pc_en, p_ifid_en, p_stall;
  logic [3:0]  p_opcode;
  logic [2:0]  p_src1, p_src2, p_dest;
  logic        s_valid, s_pc_en, s_ifid_en, s_stall;
  logic [3:0]  s_opcode;
  logic [2:0]  s_src1, s_src2, s_dest;
`endif

  id_rf_stall_ctrl #(.LOAD_LAT(1)) u_l1 (
    .clock(clock), .reset(reset), .hz_mux_enable(hz_mux_enable), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_dest(if_id_dest),
    .id_rf_valid(a_valid), .id_rf_opcode(a_opcode), .id_rf_src1(a_src1),
    .id_rf_src2(a_src2), .id_rf_dest(a_dest), .pc_enable(a_pc_en),
    .if_id_enable(a_ifid_en), .stall_active(a_stall)
`ifdef STALL_PERF_CNT_EN
    , .stall_count(a_count)
`endif
  );

  id_rf_stall_ctrl #(.LOAD_LAT(3)) u_l3 (
    .clock(clock), .reset(reset), .hz_mux_enable(hz_mux_enable), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_dest(if_id_dest),
    .id_rf_valid(b_valid), .id_rf_opcode(b_opcode), .id_rf_src1(b_src1),
    .id_rf_src2(b_src2), .id_rf_dest(b_dest), .pc_enable(b_pc_en),
    .if_id_enable(b_ifid_en), .stall_active(b_stall)
`ifdef STALL_PERF_CNT_EN
    , .stall_count(b_count)
`endif
  );

`ifdef STALL_PERF_CNT_EN
  id_rf_stall_ctrl #(.LOAD_LAT(2), .CNT_W(16)) u_p2 (
    .clock(clock), .reset(reset), .hz_mux_enable(hz_mux_enable), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_dest(if_id_dest),
    .id_rf_valid(p_valid), .id_rf_opcode(p_opcode), .id_rf_src1(p_src1),
    .id_rf_src2(p_src2), .id_rf_dest(p_dest), .pc_enable(p_pc_en),
    .if_id_enable(p_ifid_en), .stall_active(p_stall), .stall_count(p_count)
  );

  id_rf_stall_ctrl #(.LOAD_LAT(2), .CNT_W(2)) u_ps (
    .clock(clock), .reset(reset), .hz_mux_enable(hz_mux_enable), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .if_id_src1(if_id_src1), .if_id_src2(if_id_src2), .if_id_dest(if_id_dest),
    .id_rf_valid(s_valid), .id_rf_opcode(s_opcode), .id_rf_src1(s_src1),
    .id_rf_src2(s_src2), .id_rf_dest(s_dest), .pc_enable(s_pc_en),
    .if_id_enable(s_ifid_en), .stall_active(s_stall), .stall_count(s_count)
  );
`endif

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ifid(input logic v, input logic [3:0] op,
                          input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d);
    if_id_valid  = v;
    if_id_opcode = op;
    if_id_src1   = s1;
    if_id_src2   = s2;
    if_id_dest   = d;
  endtask

  task automatic reset_dut();
    reset         = 1'b1;
    hz_mux_enable = 1'b1;
    flush         = 1'b0;
    set_ifid(1'b0, 4'h0, 3'd0, 3'd0, 3'd0);
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic load_lw();
    set_ifid(1'b1, OP_LW, 3'd1, 3'd2, 3'd3);
    hz_mux_enable = 1'b1;
    tick();
  endtask

  task automatic one_hazard_ll2();
    hz_mux_enable = 1'b0;
    tick();
    hz_mux_enable = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset         = 1'b1;
    hz_mux_enable = 1'b0;
    flush         = 1'b0;
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    #3;
    chk("rst_valid",   a_valid, 0);
    chk("rst_opcode",  b_opcode, OP_NOP);
    chk("rst_src1",    b_src1, 0);
    chk("rst_pc_en",   a_pc_en, 1);
    chk("rst_ifid_en", b_ifid_en, 1);
    chk("rst_stall",   a_stall, 0);

    // 1: LOAD_LAT=1 single bubble
    reset_dut();
    load_lw();
    chk("t1_lw_opcode", a_opcode, OP_LW);
    chk("t1_lw_dest",   a_dest, 3);
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    hz_mux_enable = 1'b0;
    #1;
    chk("t1_pc_en",   a_pc_en, 0);
    chk("t1_ifid_en", a_ifid_en, 0);
    chk("t1_stall",   a_stall, 1);
    tick();
    chk("t1_bub_valid",  a_valid, 0);
    chk("t1_bub_opcode", a_opcode, OP_NOP);
    chk("t1_bub_dest",   a_dest, 0);
    hz_mux_enable = 1'b1;
    #1;
    chk("t1_release_pc_en", a_pc_en, 1);
    tick();
    chk("t1_add_valid",  a_valid, 1);
    chk("t1_add_opcode", a_opcode, OP_ADD);
    chk("t1_add_src1",   a_src1, 3);
    chk("t1_add_dest",   a_dest, 5);

    // 2: LOAD_LAT=3, three bubbles, hz ignored in STALL
    reset_dut();
    load_lw();
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    hz_mux_enable = 1'b0;
    #1;
    chk("t2_c1_pc_en",   b_pc_en, 0);
    chk("t2_c1_ifid_en", b_ifid_en, 0);
    tick();
    chk("t2_b1_valid",  b_valid, 0);
    chk("t2_b1_opcode", b_opcode, OP_NOP);
    hz_mux_enable = 1'b1;
    #1;
    chk("t2_c2_pc_en", b_pc_en, 0);
    chk("t2_c2_stall", b_stall, 1);
    tick();
    chk("t2_b2_valid", b_valid, 0);
    hz_mux_enable = 1'b0;
    #1;
    chk("t2_c3_ifid_en", b_ifid_en, 0);
    tick();
    chk("t2_b3_valid",  b_valid, 0);
    chk("t2_b3_opcode", b_opcode, OP_NOP);
    hz_mux_enable = 1'b1;
    #1;
    chk("t2_c4_pc_en", b_pc_en, 1);
    tick();
    chk("t2_add_valid",  b_valid, 1);
    chk("t2_add_opcode", b_opcode, OP_ADD);
    chk("t2_add_src2",   b_src2, 4);

    // 3: flush in 2nd stall cycle
    reset_dut();
    load_lw();
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    hz_mux_enable = 1'b0;
    tick();
    chk("t3_b1_valid", b_valid, 0);
    flush = 1'b1;
    #1;
    chk("t3_fl_pc_en", b_pc_en, 1);
    chk("t3_fl_stall", b_stall, 0);
    tick();
    flush         = 1'b0;
    hz_mux_enable = 1'b1;
    set_ifid(1'b1, OP_SUB, 3'd6, 3'd7, 3'd1);
    chk("t3_post_valid",  b_valid, 0);
    chk("t3_post_opcode", b_opcode, OP_NOP);
    #1;
    chk("t3_run_pc_en", b_pc_en, 1);
    tick();
    chk("t3_sub_valid",  b_valid, 1);
    chk("t3_sub_opcode", b_opcode, OP_SUB);
    chk("t3_sub_dest",   b_dest, 1);

    // 4: async reset mid-STALL
    reset_dut();
    load_lw();
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    hz_mux_enable = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t4_rst_valid",   b_valid, 0);
    chk("t4_rst_opcode",  b_opcode, OP_NOP);
    chk("t4_rst_pc_en",   b_pc_en, 1);
    chk("t4_rst_ifid_en", b_ifid_en, 1);
    chk("t4_rst_stall",   b_stall, 0);
    #1;
    reset         = 1'b0;
    hz_mux_enable = 1'b1;
    #1;
    chk("t4_rel_stall", b_stall, 0);
    tick();
    chk("t4_add_valid",  b_valid, 1);
    chk("t4_add_opcode", b_opcode, OP_ADD);

    // 5: hazard on an invalid slot is not a stall
    reset_dut();
    set_ifid(1'b0, 4'b0011, 3'd1, 3'd1, 3'd1);
    hz_mux_enable = 1'b0;
    #1;
    chk("t5_pc_en_l1",   a_pc_en, 1);
    chk("t5_ifid_en_l3", b_ifid_en, 1);
    chk("t5_stall_l3",   b_stall, 0);
    tick();
    chk("t5_valid_l1",  a_valid, 0);
    chk("t5_valid_l3",  b_valid, 0);
    chk("t5_opcode_l3", b_opcode, 4'b0011);

`ifdef STALL_PERF_CNT_EN
    // 6: perf counter, LOAD_LAT=2
    reset_dut();
    load_lw();
    set_ifid(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5);
    one_hazard_ll2();
    one_hazard_ll2();
    chk("t6_cnt16_2hz", p_count, 4);
    chk("t6_cnt2_2hz",  s_count, 3);
    one_hazard_ll2();
    chk("t6_cnt16_3hz", p_count, 6);
    chk("t6_cnt2_sat",  s_count, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_cnt16_flush", p_count, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
